// File: rtl/que_hs_pkg.sv
// Shared definitions for the entropy-word queue: word width, default depth
// and the registered status block layout.
package que_hs_pkg;

   localparam int WORD_WIDTH    = 256;
   localparam int DEFAULT_DEPTH = 8;

   // Status count field is sized for the largest supported depth; the top
   // exposes only the low $clog2(DEPTH+1) bits.
   localparam int STATUS_CNT_W  = 16;

   typedef struct packed {
      logic [STATUS_CNT_W-1:0] count;
      logic                    almost_full;
      logic                    almost_empty;
      logic                    overflow;
   } que_status_t;

endpackage

// File: rtl/que_ptr.sv
// Modulo-DEPTH pointer with increment and synchronous clear; the wrap is an
// explicit compare so non-power-of-two depths work.
module que_ptr
   import que_hs_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int PW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inc,
   input  logic          clr,
   output logic [PW-1:0] ptr
);

   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= (ptr == LAST) ? '0 : ptr + PW'(1);
      end
   end

endmodule

// File: rtl/que_hs.sv
// First-word-fall-through valid/ready queue for conditioned entropy words,
// with occupancy, programmable watermarks, flush and sticky overflow.
module que_hs
   import que_hs_pkg::*;
#(
   parameter int WIDTH    = WORD_WIDTH,
   parameter int DEPTH    = DEFAULT_DEPTH,
   parameter int AF_LEVEL = DEPTH - 1,
   parameter int AE_LEVEL = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic                       overflow
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   localparam logic [STATUS_CNT_W-1:0] DEPTH_C = STATUS_CNT_W'(DEPTH);
   localparam logic [STATUS_CNT_W-1:0] AF_C    = STATUS_CNT_W'(AF_LEVEL);
   localparam logic [STATUS_CNT_W-1:0] AE_C    = STATUS_CNT_W'(AE_LEVEL);
   localparam logic [STATUS_CNT_W-1:0] ONE_C   = STATUS_CNT_W'(1);

   if (DEPTH < 2) begin : g_bad_depth
      $error("que_hs: DEPTH must be >= 2");
   end
   if (CW > STATUS_CNT_W) begin : g_bad_depth_max
      $error("que_hs: DEPTH too large for status count field");
   end
   if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
      $error("que_hs: AF_LEVEL must be within 1..DEPTH");
   end
   if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
      $error("que_hs: AE_LEVEL must be within 0..DEPTH-1");
   end

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    head;
   logic [PW-1:0]    tail;
   que_status_t      status_q;
   que_status_t      status_d;
   logic             push;
   logic             pop;
   logic             drop;

   // Occupancy alone decides full/empty; head == tail is ambiguous.
   assign in_ready  = (status_q.count != DEPTH_C);
   assign out_valid = (status_q.count != '0);

   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;
   assign drop = in_valid & ~in_ready;

   always_comb begin
      status_d = status_q;
      if (flush) begin
         status_d.count    = '0;
         status_d.overflow = 1'b0;
      end else begin
         case ({push, pop})
            2'b10:   status_d.count = status_q.count + ONE_C;
            2'b01:   status_d.count = status_q.count - ONE_C;
            default: status_d.count = status_q.count;
         endcase
         if (drop) begin
            status_d.overflow = 1'b1;
         end
      end
      status_d.almost_full  = (status_d.count >= AF_C);
      status_d.almost_empty = (status_d.count <= AE_C);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         status_q <= '{count: '0, almost_full: 1'b0, almost_empty: 1'b1, overflow: 1'b0};
      end else begin
         status_q <= status_d;
      end
   end

   // Storage is deliberately left unreset and uncleared on flush.
   always_ff @(posedge clk) begin
      if (push && !flush && !rst) begin
         mem[tail] <= in_data;
      end
   end

   que_ptr #(
      .DEPTH (DEPTH),
      .PW    (PW)
   ) u_head (
      .clk   (clk),
      .rst   (rst),
      .inc   (pop & ~flush),
      .clr   (flush),
      .ptr   (head)
   );

   que_ptr #(
      .DEPTH (DEPTH),
      .PW    (PW)
   ) u_tail (
      .clk   (clk),
      .rst   (rst),
      .inc   (push & ~flush),
      .clr   (flush),
      .ptr   (tail)
   );

   assign out_data     = mem[head];
   assign count        = status_q.count[CW-1:0];
   assign almost_full  = status_q.almost_full;
   assign almost_empty = status_q.almost_empty;
   assign overflow     = status_q.overflow;

endmodule

// File: tb/tb_que_hs.sv
// Scoreboard bench for que_hs at DEPTH=5, WIDTH=8, AF_LEVEL=4, AE_LEVEL=1.
module tb_que_hs;

   localparam int W  = 8;
   localparam int D  = 5;
   localparam int AF = 4;
   localparam int AE = 1;

   logic         clk = 1'b0;
   logic         rst;
   logic         flush;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_data;
   logic [2:0]   count;
   logic         almost_full;
   logic         almost_empty;
   logic         overflow;

   int           passed = 0;
   int           total  = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_w;
   int           mcount = 0;
   logic         movf   = 1'b0;

   always #5 clk = ~clk;

   que_hs #(
      .WIDTH        (W),
      .DEPTH        (D),
      .AF_LEVEL     (AF),
      .AE_LEVEL     (AE)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .count        (count),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .overflow     (overflow)
   );

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act == req) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, req);
   endtask

   // Drive one cycle of inputs and record the expected effect in the model.
   task automatic drive(input logic iv, input logic [W-1:0] d, input logic ordy,
                        input logic fl, input logic rs);
      logic pu, po;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      rst       = rs;
      if (rs || fl) begin
         exp_q.delete();
         mcount = 0;
         movf   = 1'b0;
      end else begin
         pu = iv && (mcount < D);
         po = ordy && (mcount > 0);
         if (iv && !pu) movf = 1'b1;
         if (pu) exp_q.push_back(d);
         mcount = mcount + int'(pu) - int'(po);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      check("count",        int'(count),        mcount);
      check("in_ready",     int'(in_ready),     int'(mcount != D));
      check("out_valid",    int'(out_valid),    int'(mcount != 0));
      check("almost_full",  int'(almost_full),  int'(mcount >= AF));
      check("almost_empty", int'(almost_empty), int'(mcount <= AE));
      check("overflow",     int'(overflow),     int'(movf));
   endtask

   // Monitor: every accepted output word must match the oldest expected word.
   always @(negedge clk) begin
      if (rst === 1'b0 && flush === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            $display("FAIL pop_unexpected: got data %0h, expected no output", out_data);
         end else begin
            exp_w = exp_q.pop_front();
            check("pop_data", int'(out_data), int'(exp_w));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      tick();
      tick();
      check("rst_count",     int'(count),        0);
      check("rst_in_ready",  int'(in_ready),     1);
      check("rst_out_valid", int'(out_valid),    0);
      check("rst_af",        int'(almost_full),  0);
      check("rst_ae",        int'(almost_empty), 1);
      check("rst_ovf",       int'(overflow),     0);

      // Fill to full, then drain in order.
      for (int i = 0; i < D; i++) begin
         drive(1'b1, 8'(8'h11 + i), 1'b0, 1'b0, 1'b0);
         tick();
      end
      check("full_in_ready", int'(in_ready), 0);
      check("full_count",    int'(count),    5);
      for (int i = 0; i < D; i++) begin
         drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
         tick();
      end
      check("drained_valid", int'(out_valid), 0);

      // Steady push+pop at occupancy 2 across several pointer wraps.
      drive(1'b1, 8'h20, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 8'h21, 1'b0, 1'b0, 1'b0);
      tick();
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 8'(8'h22 + i), 1'b1, 1'b0, 1'b0);
         tick();
         check("steady_count", int'(count), 2);
      end
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      tick();

      // First-word fall-through latency from empty, no same-cycle bypass.
      drive(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
      check("nobypass_valid", int'(out_valid), 0);
      tick();
      check("fwft_valid", int'(out_valid), 1);
      check("fwft_data",  int'(out_data),  8'hA5);
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      tick();

      // Push into a full queue: dropped, sticky overflow.
      for (int i = 0; i < D; i++) begin
         drive(1'b1, 8'(8'h31 + i), 1'b0, 1'b0, 1'b0);
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
         tick();
         check("ovf_set",    int'(overflow), 1);
         check("ovf_count",  int'(count),    5);
         check("ovf_head",   int'(out_data), 8'h31);
      end
      for (int i = 0; i < D; i++) begin
         drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
         tick();
      end
      check("ovf_sticky", int'(overflow), 1);

      // Flush at count 3 with push and pop also requested.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 8'(8'h41 + i), 1'b0, 1'b0, 1'b0);
         tick();
      end
      check("pre_flush_count", int'(count), 3);
      drive(1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
      tick();
      check("flush_count", int'(count),        0);
      check("flush_valid", int'(out_valid),    0);
      check("flush_ovf",   int'(overflow),     0);
      check("flush_ae",    int'(almost_empty), 1);
      drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
      tick();
      check("post_flush_data", int'(out_data), 8'h55);
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      tick();

      // Reset together with flush while full and overflowed.
      for (int i = 0; i < D; i++) begin
         drive(1'b1, 8'(8'h61 + i), 1'b0, 1'b0, 1'b0);
         tick();
      end
      drive(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 8'h77, 1'b1, 1'b1, 1'b1);
      tick();
      check("rst2_count",     int'(count),        0);
      check("rst2_in_ready",  int'(in_ready),     1);
      check("rst2_out_valid", int'(out_valid),    0);
      check("rst2_af",        int'(almost_full),  0);
      check("rst2_ae",        int'(almost_empty), 1);
      check("rst2_ovf",       int'(overflow),     0);
      drive(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
      tick();
      check("after_rst_data", int'(out_data), 8'h3C);
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      tick();

      check("leftover_words", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
